ifu_fetch: RTL
==============

# ifu_fetch

Instruction-fetch unit holding the architectural PC and driving instruction-memory requests. It is the consumer side of next-PC generation: it takes a taken-redirect target (`redirect_pc`) or advances sequentially by 4 on its own. It delivers `{pc, instr}` pairs to decode through a valid/ready handshake. It sits between the next-PC logic and the decode stage and tolerates variable-latency instruction memory.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: first fetch address after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  a taken branch, jump or jr target is presented this cycle.
- `redirect_pc`  in  32  redirect target address.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  32  word address of the request; low 2 bits are always 0.
- `imem_ack`  in  1  response valid; may assert in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word, sampled when `imem_ack` is high.
- `out_valid`  out  1  fetched instruction is available.
- `out_ready`  in  1  decode accepts the instruction.
- `out_pc`  out  32  PC of the delivered instruction.
- `out_instr`  out  32  delivered instruction word.
- `out_exc`  out  1  misaligned-fetch exception marker; see Configuration.

## Operation
- States:
  - RESET: only while `rst_n` is low.
  - REQ: request outstanding.
  - HOLD: output register is full.
- Registers:
  - `fetch_pc`: address being requested.
  - `kill`: the outstanding response must be discarded.
  - `pend_pc`: redirect target captured while a request was in flight.
  - Output register: `out_pc`, `out_instr`, `out_exc`.
- REQ behaviour:
  - `imem_req`=1 and `imem_addr`=`fetch_pc`, held stable until `imem_ack`. A request is never withdrawn.
  - On ack with `kill`=0 and no redirect: capture `{fetch_pc, imem_rdata}` into the output register and go to HOLD.
  - On ack with `kill`=1: discard the data, clear `kill`, set `fetch_pc`=`pend_pc`, stay in REQ.
  - On ack with `redirect_valid` the same cycle: discard the data, set `fetch_pc`=`redirect_pc`, stay in REQ.
  - No ack with `redirect_valid`: set `kill`=1 and `pend_pc`=`redirect_pc`. If several redirects arrive while waiting, the last one wins.
- HOLD behaviour:
  - `out_valid`=1 and `imem_req`=0.
  - Handshake (`out_valid & out_ready`): go to REQ. Next `fetch_pc` is `redirect_pc` if `redirect_valid`, else `out_pc`+4. The handshake completes even if a redirect arrives in the same cycle.
  - `redirect_valid` without a handshake: drop the held instruction, set `fetch_pc`=`redirect_pc`, go to REQ.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 with no flag.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `out_valid`=0, `out_pc`=0, `out_instr`=0, `out_exc`=0.
  - `kill`=0, `fetch_pc`=`RESET_PC`.
- First `imem_req` is driven in the first rising edge after reset deassertion, i.e. the first cycle after `rst_n` rises. The state leaves RESET into REQ.
- Latency: ack in cycle t gives `out_valid`=1 in cycle t+1.
- Throughput: with a zero-wait memory, one instruction every 2 cycles (REQ, HOLD).
- `imem_ack` while `imem_req`=0 is ignored.
- Reset asserted mid-request: all state clears immediately. An ack arriving after reset releases is dropped unless a new request is outstanding.

## Configuration
- `IFU_MISALIGN_EXC_EN` defined:
  - A target with `[1:0]`≠0 issues no memory request.
  - The unit enters HOLD directly with `out_pc`=target, `out_instr`=32'h0000_0000 and `out_exc`=1.
  - After that handshake, fetch stays stalled (no request) until the next `redirect_valid`.
- `IFU_MISALIGN_EXC_EN` undefined:
  - Target bits `[1:0]` are forced to 0 and fetch proceeds normally.
  - `out_exc` is tied to 0.

## Test plan
- Reset release, zero-wait memory, `out_ready`=1:
  - Requests at 0x3000, 0x3004 and 0x3008 on cycles 1, 3 and 5.
  - `out_valid` on cycles 2, 4 and 6 with matching PCs.
- Ack delayed 3 cycles at 0x3004, `redirect_valid`/0x4000 in the first wait cycle:
  - `imem_addr` stays 0x3004 until ack.
  - The response is discarded and never appears at the output.
  - Next request is 0x4000.
- HOLD at 0x3008 with `out_ready`=0, then `redirect_valid`/0x5000:
  - 0x3008 is never accepted.
  - Next request is 0x5000.
- HOLD at 0x3000 with `out_ready`=1 and `redirect_valid`/0x6000 in the same cycle:
  - 0x3000 is delivered.
  - Next request is 0x6000, not 0x3004.
- Redirect to 0xFFFF_FFFC:
  - Next sequential request wraps to 0x0000_0000.
- Redirect to 0x3002:
  - With `IFU_MISALIGN_EXC_EN`: `out_exc`=1, `out_pc`=0x3002, no `imem_req` until the next redirect.
  - Without it: a request at 0x3000.

Source files
------------

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_fetch
//  Purpose  : Instruction-fetch unit. Holds the architectural fetch PC,
//             issues instruction-memory requests that stay stable until
//             acknowledged, and hands {pc, instr} pairs to decode through
//             a valid/ready output register. Tolerates any memory latency,
//             including an ack in the same cycle as the request.
//
//  Ports    : clk            - rising-edge clock
//             rst_n          - asynchronous active-low reset
//             redirect_valid - taken branch/jump target presented this cycle
//             redirect_pc    - redirect target address
//             imem_req       - instruction-memory request
//             imem_addr      - word address of the request
//             imem_ack       - response valid (may coincide with imem_req)
//             imem_rdata     - instruction word, sampled on imem_ack
//             out_valid      - fetched instruction available to decode
//             out_ready      - decode accepts the instruction
//             out_pc         - PC of the delivered instruction
//             out_instr      - delivered instruction word
//             out_exc        - misaligned-fetch exception marker
//
//  Config   : IFU_MISALIGN_EXC_EN - when defined, a misaligned target raises
//             an exception record instead of being fetched; when undefined
//             the low two target bits are forced to zero and out_exc is 0.
//
//  Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc
);

  // ST_STALL is only reachable when the misaligned exception is enabled:
  // after an exception record is consumed, fetch waits for a redirect.
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_STALL = 2'd3
  } state_e;

  state_e      state_q,     state_d;
  logic [31:0] fetch_pc_q,  fetch_pc_d;
  logic        kill_q,      kill_d;
  logic [31:0] pend_pc_q,   pend_pc_d;
  logic [31:0] out_pc_q,    out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;

  // A "launch" starts fetching from a new target. All the paths that
  // change the fetch address funnel through it, so alignment handling
  // lives in exactly one place.
  logic        launch;
  logic [31:0] launch_pc;

`ifdef IFU_MISALIGN_EXC_EN
  logic        out_exc_q, out_exc_d;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      fetch_pc_q  <= RESET_PC;
      kill_q      <= 1'b0;
      pend_pc_q   <= 32'h0000_0000;
      out_pc_q    <= 32'h0000_0000;
      out_instr_q <= 32'h0000_0000;
`ifdef IFU_MISALIGN_EXC_EN
      out_exc_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      kill_q      <= kill_d;
      pend_pc_q   <= pend_pc_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
`ifdef IFU_MISALIGN_EXC_EN
      out_exc_q   <= out_exc_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    kill_d      = kill_q;
    pend_pc_d   = pend_pc_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
`ifdef IFU_MISALIGN_EXC_EN
    out_exc_d   = out_exc_q;
`endif
    launch      = 1'b0;
    launch_pc   = fetch_pc_q;
    imem_req    = 1'b0;
    out_valid   = 1'b0;

    case (state_q)
      ST_RESET: begin
        // First cycle out of reset: begin fetching at fetch_pc (RESET_PC).
        state_d = ST_REQ;
      end

      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (redirect_valid) begin
            // A redirect in the ack cycle is newer than anything pending.
            kill_d    = 1'b0;
            launch    = 1'b1;
            launch_pc = redirect_pc;
          end else if (kill_q) begin
            // Response belongs to a squashed path; refetch the saved target.
            kill_d    = 1'b0;
            launch    = 1'b1;
            launch_pc = pend_pc_q;
          end else begin
            out_pc_d    = fetch_pc_q;
            out_instr_d = imem_rdata;
`ifdef IFU_MISALIGN_EXC_EN
            out_exc_d   = 1'b0;
`endif
            state_d     = ST_HOLD;
          end
        end else if (redirect_valid) begin
          // The request cannot be withdrawn, so remember to drop its data.
          // A later redirect simply overwrites the saved target.
          kill_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
      end

      ST_HOLD: begin
        out_valid = 1'b1;
        if (redirect_valid) begin
          // Covers both the handshake+redirect case (instruction is still
          // delivered this cycle) and the drop-without-handshake case.
          launch    = 1'b1;
          launch_pc = redirect_pc;
        end else if (out_ready) begin
          launch    = 1'b1;
          launch_pc = out_pc_q + 32'd4;
`ifdef IFU_MISALIGN_EXC_EN
          if (out_exc_q) begin
            launch  = 1'b0;
            state_d = ST_STALL;
          end
`endif
        end
      end

      ST_STALL: begin
        if (redirect_valid) begin
          launch    = 1'b1;
          launch_pc = redirect_pc;
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase

    if (launch) begin
`ifdef IFU_MISALIGN_EXC_EN
      if (launch_pc[1:0] != 2'b00) begin
        // Misaligned target: produce an exception record, no memory access.
        out_pc_d    = launch_pc;
        out_instr_d = 32'h0000_0000;
        out_exc_d   = 1'b1;
        state_d     = ST_HOLD;
      end else begin
        fetch_pc_d  = launch_pc;
        state_d     = ST_REQ;
      end
`else
      fetch_pc_d = launch_pc & ~32'h0000_0003;
      state_d    = ST_REQ;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_addr = fetch_pc_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

`ifdef IFU_MISALIGN_EXC_EN
  assign out_exc   = out_exc_q;
`else
  assign out_exc   = 1'b0;
`endif

endmodule
`default_nettype wire
